bus_master_sram: RTL and testbench
==================================

// Module: bus_master_sram
// PURPOSE
// - FPGA-side bus initiator: takes the Z8S180 bus via /BUSREQ-/BUSACK and runs SRAM read/write cycles itself.
// - Sits beside the boot-ROM responder in the top level; used for SRAM preload/inspection while the CPU is held off the bus.
// - Internal side is a valid/ready command port; external side drives a/d/ce_n/oe_n/we_n only while granted.
// PARAMETERS
// - SETUP_CYC   2   hwclk cycles with address/data stable before the strobe asserts (>=1)
// - STROBE_CYC  3   hwclk cycles of oe_n/we_n low; read data is sampled on the last one (>=1)
// - HOLD_CYC    1   hwclk cycles with address/data held after the strobe deasserts (>=1)
// - IDLE_CYC    8   idle cycles the bus is kept after a command before it is released (>=1)
// PORTS
// - hwclk       in   1   system clock
// - reset_n     in   1   asynchronous active-low reset
// - cmd_valid   in   1   command offered
// - cmd_ready   out  1   command accepted when cmd_valid&&cmd_ready
// - cmd_we      in   1   1=write, 0=read
// - cmd_addr    in   20  SRAM byte address
// - cmd_wdata   in   8   write data
// - rsp_valid   out  1   one-cycle pulse: read data valid / write complete
// - rsp_rdata   out  8   read data, held until next read completes
// - busack_n    in   1   CPU grant, asynchronous to hwclk
// - busreq_n    out  1   bus request to the CPU
// - a_out       out  20  address drive value
// - a_oe        out  1   address/control drive enable (top level tri-states a when 0)
// - d_out       out  8   data drive value
// - d_oe        out  1   data drive enable, writes only
// - d_in        in   8   data bus sampled value
// - ce_n/oe_n/we_n out 1 SRAM strobes, valid only while a_oe=1
// - busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
// - Reset: busreq_n=1, a_oe=0, d_oe=0, ce_n=oe_n=we_n=1, cmd_ready=0, rsp_valid=0, rsp_rdata=0, a_out=0, d_out=0, state=IDLE.
// - busack_n goes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
// - States: IDLE, REQ, SETUP, STROBE, HOLD, OWN, REL_DRV, REL_WAIT.
// - IDLE: cmd_valid -> REQ, busreq_n=0. No command is accepted in IDLE.
// - REQ: wait for sync busack_n=0, then a_oe=1 and -> OWN. No timeout; busreq_n stays low.
// - OWN: cmd_ready=1. On handshake, latch addr/we/wdata; a_out=addr, ce_n=0, d_oe=we -> SETUP.
//   With no command for IDLE_CYC consecutive cycles -> REL_DRV.
// - SETUP: SETUP_CYC cycles, then -> STROBE.
// - STROBE: STROBE_CYC cycles with oe_n=~rd / we_n=~we low. On a read, rsp_rdata<=d_in on the last cycle. -> HOLD.
// - HOLD: strobes high; HOLD_CYC cycles, then ce_n=1, d_oe=0, rsp_valid pulses one cycle -> OWN, idle counter cleared.
// - Back-to-back: a command waiting in OWN is taken the first OWN cycle after HOLD (1 idle bus cycle between accesses).
// - REL_DRV: a_oe=0, d_oe=0, strobes high for 1 cycle; then busreq_n=1 -> REL_WAIT.
// - REL_WAIT: wait for sync busack_n=1, then -> IDLE.
// - A cmd_valid seen in REL_* is not accepted; it is re-requested from IDLE.
// - Grant loss: if sync busack_n=1 in any owned state, go to REL_DRV at once (drivers off).
//   Any in-flight command is dropped with no rsp_valid, and busy stays high until IDLE.
// - Never drive: a_oe=1 only after sync grant; d_oe=1 implies a_oe=1 and we.
// - cmd_ready is 1 only in OWN; it is never combinationally dependent on cmd_valid.
// - Phase counters sized $clog2(max param)+1; each loads param-1 and counts to 0.
// - Async reset mid-access drops all drivers and strobes in the same instant.
// STRUCTURE
// - Shared package z8s180_pkg: state enum encoding, ADDR_W=20, DATA_W=8, SRAM base 20'h200 constant.
// - Sub-module: sync2 (2-flop synchronizer with reset value parameter), reused for busack_n.
// - Top level muxes a/d: the ROM responder drives d only when a_oe=0.
// TESTING
// - Write 0xA5 to 0x00200, busack granted 5 cycles after busreq_n falls -> we_n low exactly STROBE_CYC cycles; d_oe=1 from SETUP to end of HOLD; rsp_valid once.
// - Write 0x3C to 0x12345, then read 0x12345 on an SRAM model -> rsp_rdata=0x3C; oe_n low 3 cycles; d_oe stays 0 during the read.
// - 4 back-to-back writes with cmd_valid held -> one busreq_n assertion; 4 rsp_valid pulses; busreq_n high IDLE_CYC+1 cycles after last HOLD.
// - Deassert busack_n during STROBE -> drivers off within 3 cycles of the busack_n edge; no rsp_valid; returns to IDLE after busack sync.
// - Assert reset_n=0 mid-SETUP -> all outputs at reset values asynchronously; a later command completes normally.
// - busack_n held at 1 forever -> busreq_n stays 0, cmd_ready stays 0, a_oe/d_oe never assert.

Source files
------------

// File: rtl/z8s180_pkg.sv
// Shared definitions for the Z8S180 FPGA bus side: bus widths, the SRAM
// window base and the bus-master state encoding.
package z8s180_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  // First SRAM byte address in the Z8S180 physical map.
  localparam logic [ADDR_W-1:0] SRAM_BASE = 20'h00200;

  // Bus-master states. Explicit encoding keeps the debug port stable.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_SETUP    = 3'd2,
    S_STROBE   = 3'd3,
    S_HOLD     = 3'd4,
    S_OWN      = 3'd5,
    S_REL_DRV  = 3'd6,
    S_REL_WAIT = 3'd7
  } state_e;

  // Larger of two integers, used to size shared phase counters.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_master_sram_if.sv
// Command port and Z8S180/SRAM bus signals of the FPGA bus master.
//
// Command handshake: a command transfers on a rising clock edge where
// cmd_valid && cmd_ready are both 1. cmd_valid and the command fields must
// stay stable until that edge; cmd_ready never depends on cmd_valid.
// rsp_valid is a one-cycle pulse with no back-pressure.
interface bus_master_sram_if;
  import z8s180_pkg::*;

  // internal command / response side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  // CPU bus arbitration
  logic              busack_n;
  logic              busreq_n;

  // SRAM bus drive values and enables
  logic [ADDR_W-1:0] a_out;
  logic              a_oe;
  logic [DATA_W-1:0] d_out;
  logic              d_oe;
  logic [DATA_W-1:0] d_in;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;

  // status
  logic              busy;
  state_e            dbg_state;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, busack_n, d_in,
    output cmd_ready, rsp_valid, rsp_rdata, busreq_n,
           a_out, a_oe, d_out, d_oe, ce_n, oe_n, we_n, busy, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, busack_n, d_in,
    input  cmd_ready, rsp_valid, rsp_rdata, busreq_n,
           a_out, a_oe, d_out, d_oe, ce_n, oe_n, we_n, busy, dbg_state
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a
// configurable reset value so an inactive level can be assumed at reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bus_master_sram.sv
// FPGA-side bus initiator: requests the Z8S180 bus with busreq_n, and once
// granted runs SRAM read/write cycles from a valid/ready command port.
// The bus is kept for IDLE_CYC idle cycles after a command, then released.
// All strobes and drive enables are registered so they come straight off
// flops and drop together on asynchronous reset.
module bus_master_sram
  import z8s180_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int IDLE_CYC   = 8
) (
  input  logic              hwclk,
  input  logic              reset_n,
  bus_master_sram_if.master bus
);

  localparam int MAX_CYC = max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, IDLE_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Each phase counter loads N-1 and the phase ends on the cycle it reads 0.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD   = CNT_W'(IDLE_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busreq_n_q, busreq_n_d;
  logic              a_oe_q, a_oe_d;
  logic              d_oe_q, d_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [ADDR_W-1:0] a_out_q, a_out_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic busack_sync;   // synchronized busack_n, 1 = not granted
  logic owned;         // states in which the FPGA is driving the bus
  logic cmd_ready_w;

  // busack_n comes from the CPU clock domain.
  sync2 #(.RST_VAL(1'b1)) u_busack_sync (
    .clk_i  (hwclk),
    .rst_ni (reset_n),
    .d_i    (bus.busack_n),
    .q_o    (busack_sync)
  );

  assign owned = (state_q == S_OWN) || (state_q == S_SETUP) ||
                 (state_q == S_STROBE) || (state_q == S_HOLD);

  // Not ready once the grant is seen gone, so no command is taken and lost.
  assign cmd_ready_w = (state_q == S_OWN) && !busack_sync;

  // State and all registered bus outputs.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busreq_n_q  <= 1'b1;
      a_oe_q      <= 1'b0;
      d_oe_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      a_out_q     <= '0;
      d_out_q     <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busreq_n_q  <= busreq_n_d;
      a_oe_q      <= a_oe_d;
      d_oe_q      <= d_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      a_out_q     <= a_out_d;
      d_out_q     <= d_out_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next state and next output values; everything holds unless changed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busreq_n_d  = busreq_n_q;
    a_oe_d      = a_oe_q;
    d_oe_d      = d_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    a_out_d     = a_out_q;
    d_out_d     = d_out_q;
    we_d        = we_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    if (owned && busack_sync) begin
      // Grant lost: get off the bus immediately, drop any access in flight.
      state_d = S_REL_DRV;
      a_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state_d    = S_REQ;
            busreq_n_d = 1'b0;
          end
        end
        S_REQ: begin
          if (!busack_sync) begin
            state_d = S_OWN;
            a_oe_d  = 1'b1;
            cnt_d   = IDLE_LD;
          end
        end
        S_OWN: begin
          if (bus.cmd_valid && cmd_ready_w) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            a_out_d = bus.cmd_addr;
            d_out_d = bus.cmd_wdata;
            we_d    = bus.cmd_we;
            ce_n_d  = 1'b0;
            d_oe_d  = bus.cmd_we;
          end else if (cnt_q == '0) begin
            state_d = S_REL_DRV;
            a_oe_d  = 1'b0;
            d_oe_d  = 1'b0;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_d = S_STROBE;
            cnt_d   = STROBE_LD;
            oe_n_d  = we_q;
            we_n_d  = ~we_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (cnt_q == '0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            if (!we_q) begin
              rsp_rdata_d = bus.d_in;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d     = S_OWN;
            cnt_d       = IDLE_LD;
            ce_n_d      = 1'b1;
            d_oe_d      = 1'b0;
            rsp_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_REL_DRV: begin
          // Drivers were turned off on entry; one quiet cycle, then release.
          state_d    = S_REL_WAIT;
          busreq_n_d = 1'b1;
          a_oe_d     = 1'b0;
          d_oe_d     = 1'b0;
        end
        S_REL_WAIT: begin
          if (busack_sync) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busreq_n  = busreq_n_q;
  assign bus.a_out     = a_out_q;
  assign bus.a_oe      = a_oe_q;
  assign bus.d_out     = d_out_q;
  assign bus.d_oe      = d_oe_q;
  assign bus.ce_n      = ce_n_q;
  assign bus.oe_n      = oe_n_q;
  assign bus.we_n      = we_n_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bus_master_sram.sv
// Directed bench for bus_master_sram with a behavioural CPU grant model and
// a small asynchronous SRAM model. Inputs change and outputs are sampled on
// the falling edge of hwclk.
module tb_bus_master_sram;
  import z8s180_pkg::*;

  localparam int GRANT_DLY = 5;

  logic hwclk = 1'b0;
  logic reset_n;
  logic cpu_deny;
  int   total = 0;
  int   bad = 0;

  bus_master_sram_if bus ();

  bus_master_sram #(
    .SETUP_CYC (2),
    .STROBE_CYC(3),
    .HOLD_CYC  (1),
    .IDLE_CYC  (8)
  ) dut (
    .hwclk  (hwclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 hwclk = ~hwclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- CPU grant model ----------------
  logic busack_auto = 1'b1;
  int   grant_wait = 0;
  always @(negedge hwclk) begin
    if (bus.busreq_n) begin
      busack_auto = 1'b1;
      grant_wait  = 0;
    end else if (busack_auto) begin
      if (grant_wait >= GRANT_DLY) busack_auto = 1'b0;
      else grant_wait++;
    end
  end
  assign bus.busack_n = busack_auto | cpu_deny;

  // ---------------- SRAM model (256 bytes, low address byte) ----------------
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge hwclk) begin
    if (bus.a_oe && bus.d_oe && !bus.ce_n && !bus.we_n) mem[bus.a_out[7:0]] <= bus.d_out;
  end
  assign bus.d_in = (bus.a_oe && !bus.ce_n && !bus.oe_n) ? mem[bus.a_out[7:0]] : 8'hEE;

  // ---------------- monitor ----------------
  int   rsp_cnt = 0;
  int   breq_falls = 0;
  int   viol = 0;
  logic breq_prev = 1'b1;
  always @(negedge hwclk) begin
    if (bus.rsp_valid === 1'b1) rsp_cnt++;
    if (breq_prev === 1'b1 && bus.busreq_n === 1'b0) breq_falls++;
    breq_prev = bus.busreq_n;
    if (bus.d_oe === 1'b1 && !(bus.a_oe === 1'b1 && bus.oe_n === 1'b1)) viol++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge hwclk);
  endtask

  // Offer one command and return at the first falling edge after it transfers.
  task automatic send_cmd(input logic we, input logic [19:0] addr, input logic [7:0] wdata);
    int w;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    total++;
    if (w >= 200) begin
      bad++;
      $display("FAIL send_cmd_timeout: waited %0d cycles, want cmd_ready within 200", w);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Observe n cycles and count strobe/enable activity.
  task automatic run_window(input int n, output int we_lo, output int oe_lo, output int doe_hi,
                            output int ce_lo, output int rsp, output logic [7:0] rdata);
    we_lo = 0; oe_lo = 0; doe_hi = 0; ce_lo = 0; rsp = 0; rdata = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (bus.we_n === 1'b0) we_lo++;
      if (bus.oe_n === 1'b0) oe_lo++;
      if (bus.d_oe === 1'b1) doe_hi++;
      if (bus.ce_n === 1'b0) ce_lo++;
      if (bus.rsp_valid === 1'b1) begin
        rsp++;
        rdata = bus.rsp_rdata;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (bus.busy !== 1'b0 && w < 60) begin
      tick();
      w++;
    end
    total++;
    if (w >= 60) begin
      bad++;
      $display("FAIL %s: busy still %b after %0d cycles, want 0", name, bus.busy, w);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] flags;
    reset_n = 1'b0;
    repeat (3) tick();
    flags = {bus.busreq_n, bus.a_oe, bus.d_oe, bus.ce_n, bus.oe_n, bus.we_n,
             bus.cmd_ready, bus.rsp_valid, bus.busy};
    total++;
    if (flags !== 9'b100111000) begin
      bad++; $display("FAIL reset_flags: got %b want %b", flags, 9'b100111000);
    end
    total++;
    if (bus.rsp_rdata !== 8'h00) begin
      bad++; $display("FAIL reset_rdata: got %h want 00", bus.rsp_rdata);
    end
    total++;
    if (bus.a_out !== 20'h0 || bus.d_out !== 8'h0) begin
      bad++; $display("FAIL reset_a_d: got a=%h d=%h want 0/0", bus.a_out, bus.d_out);
    end
    total++;
    if (bus.dbg_state !== S_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, S_IDLE);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_a5();
    int we_lo, oe_lo, doe_hi, ce_lo, rsp, b0;
    logic [7:0] rd;
    b0 = breq_falls;
    send_cmd(1'b1, SRAM_BASE, 8'hA5);
    run_window(10, we_lo, oe_lo, doe_hi, ce_lo, rsp, rd);
    total++;
    if (we_lo != 3) begin bad++; $display("FAIL wr_we_low: got %0d want 3", we_lo); end
    total++;
    if (doe_hi != 6) begin bad++; $display("FAIL wr_d_oe: got %0d want 6", doe_hi); end
    total++;
    if (ce_lo != 6) begin bad++; $display("FAIL wr_ce_low: got %0d want 6", ce_lo); end
    total++;
    if (rsp != 1) begin bad++; $display("FAIL wr_rsp: got %0d want 1", rsp); end
    total++;
    if (bus.a_out !== SRAM_BASE || bus.d_out !== 8'hA5) begin
      bad++; $display("FAIL wr_a_d: got a=%h d=%h want 00200/a5", bus.a_out, bus.d_out);
    end
    total++;
    if (mem[8'h00] !== 8'hA5) begin bad++; $display("FAIL wr_mem: got %h want a5", mem[8'h00]); end
    total++;
    if (breq_falls - b0 != 1) begin
      bad++; $display("FAIL wr_busreq: got %0d want 1", breq_falls - b0);
    end
  endtask

  task automatic test_write_read();
    int we_lo, oe_lo, doe_hi, ce_lo, rsp;
    logic [7:0] rd;
    send_cmd(1'b1, 20'h12345, 8'h3C);
    run_window(10, we_lo, oe_lo, doe_hi, ce_lo, rsp, rd);
    send_cmd(1'b0, 20'h12345, 8'h00);
    run_window(10, we_lo, oe_lo, doe_hi, ce_lo, rsp, rd);
    total++;
    if (oe_lo != 3) begin bad++; $display("FAIL rd_oe_low: got %0d want 3", oe_lo); end
    total++;
    if (doe_hi != 0 || we_lo != 0) begin
      bad++; $display("FAIL rd_no_drive: got d_oe=%0d we=%0d want 0/0", doe_hi, we_lo);
    end
    total++;
    if (rsp != 1) begin bad++; $display("FAIL rd_rsp: got %0d want 1", rsp); end
    total++;
    if (rd !== 8'h3C) begin bad++; $display("FAIL rd_data: got %h want 3c", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] e;
    int b0, r0, w, n;
    wait_idle("b2b_start_idle");
    b0 = breq_falls;
    r0 = rsp_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.cmd_addr  = SRAM_BASE + 20'(16 + k);
      bus.cmd_wdata = dat[k];
      w = 0;
      while (bus.cmd_ready !== 1'b1 && w < 200) begin
        tick();
        w++;
      end
      if (k > 0) begin
        total++;
        if (w != 6) begin bad++; $display("FAIL b2b_gap%0d: got %0d cycles want 6", k, w); end
      end
      exp_q.push_back(dat[k]);
      tick();
    end
    bus.cmd_valid = 1'b0;
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n = 0;
    while (bus.busreq_n !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (n != 9) begin bad++; $display("FAIL b2b_release: got %0d cycles want 9", n); end
    total++;
    if (rsp_cnt - r0 != 4) begin bad++; $display("FAIL b2b_rsp: got %0d want 4", rsp_cnt - r0); end
    total++;
    if (breq_falls - b0 != 1) begin
      bad++; $display("FAIL b2b_busreq: got %0d want 1", breq_falls - b0);
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      total++;
      if (mem[8'(16 + k)] !== e) begin
        bad++; $display("FAIL b2b_mem%0d: got %h want %h", k, mem[8'(16 + k)], e);
      end
    end
  endtask

  task automatic test_grant_loss();
    logic [4:0] drv;
    int w, r0;
    wait_idle("gl_start_idle");
    send_cmd(1'b0, SRAM_BASE, 8'h00);
    w = 0;
    while (bus.oe_n !== 1'b0 && w < 10) begin
      tick();
      w++;
    end
    r0 = rsp_cnt;
    cpu_deny = 1'b1;
    repeat (3) tick();
    drv = {bus.a_oe, bus.d_oe, bus.ce_n, bus.oe_n, bus.we_n};
    total++;
    if (drv !== 5'b00111) begin bad++; $display("FAIL gl_drivers_off: got %b want 00111", drv); end
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL gl_busy: got %b want 1", bus.busy); end
    wait_idle("gl_back_idle");
    repeat (3) tick();
    total++;
    if (rsp_cnt != r0) begin bad++; $display("FAIL gl_no_rsp: got %0d want 0", rsp_cnt - r0); end
    total++;
    if (bus.rsp_rdata !== 8'h3C) begin
      bad++; $display("FAIL gl_rdata_kept: got %h want 3c", bus.rsp_rdata);
    end
    cpu_deny = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_setup();
    int we_lo, oe_lo, doe_hi, ce_lo, rsp;
    logic [7:0] rd;
    logic [8:0] flags;
    send_cmd(1'b1, SRAM_BASE + 20'h101, 8'h77);
    total++;
    if (bus.dbg_state !== S_SETUP) begin
      bad++; $display("FAIL rst_in_setup: got %0d want %0d", bus.dbg_state, S_SETUP);
    end
    reset_n = 1'b0;
    #1;
    flags = {bus.busreq_n, bus.a_oe, bus.d_oe, bus.ce_n, bus.oe_n, bus.we_n,
             bus.cmd_ready, bus.rsp_valid, bus.busy};
    total++;
    if (flags !== 9'b100111000) begin
      bad++; $display("FAIL rst_async_flags: got %b want %b", flags, 9'b100111000);
    end
    total++;
    if (bus.a_out !== 20'h0 || bus.d_out !== 8'h0 || bus.rsp_rdata !== 8'h0) begin
      bad++; $display("FAIL rst_async_regs: got a=%h d=%h r=%h want 0", bus.a_out, bus.d_out, bus.rsp_rdata);
    end
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (mem[8'h01] !== 8'h00) begin bad++; $display("FAIL rst_no_write: got %h want 00", mem[8'h01]); end
    send_cmd(1'b1, SRAM_BASE + 20'h101, 8'h5A);
    run_window(10, we_lo, oe_lo, doe_hi, ce_lo, rsp, rd);
    total++;
    if (rsp != 1 || we_lo != 3) begin
      bad++; $display("FAIL rst_after_cmd: got rsp=%0d we=%0d want 1/3", rsp, we_lo);
    end
    total++;
    if (mem[8'h01] !== 8'h5A) begin bad++; $display("FAIL rst_after_mem: got %h want 5a", mem[8'h01]); end
  endtask

  task automatic test_no_grant();
    int hi, rdy, drv, w;
    wait_idle("ng_start_idle");
    cpu_deny      = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = SRAM_BASE + 20'h005;
    bus.cmd_wdata = 8'h99;
    repeat (2) tick();
    hi = 0; rdy = 0; drv = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busreq_n !== 1'b0) hi++;
      if (bus.cmd_ready !== 1'b0) rdy++;
      if (bus.a_oe !== 1'b0 || bus.d_oe !== 1'b0) drv++;
      tick();
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL ng_busreq: got %0d high cycles want 0", hi); end
    total++;
    if (rdy != 0) begin bad++; $display("FAIL ng_ready: got %0d ready cycles want 0", rdy); end
    total++;
    if (drv != 0) begin bad++; $display("FAIL ng_drive: got %0d drive cycles want 0", drv); end
    total++;
    if (bus.dbg_state !== S_REQ) begin
      bad++; $display("FAIL ng_state: got %0d want %0d", bus.dbg_state, S_REQ);
    end
    cpu_deny = 1'b0;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    tick();
    bus.cmd_valid = 1'b0;
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (mem[8'h05] !== 8'h99) begin bad++; $display("FAIL ng_late_write: got %h want 99", mem[8'h05]); end
  endtask

  task automatic test_invariants();
    total++;
    if (viol != 0) begin bad++; $display("FAIL d_oe_without_a_oe: got %0d cycles want 0", viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n       = 1'b0;
    cpu_deny      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    test_reset();
    test_write_a5();
    test_write_read();
    test_back_to_back();
    test_grant_loss();
    test_reset_mid_setup();
    test_no_grant();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
